fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 31-instruction MIPS core.
- Holds the PC, computes the next PC from sequential, branch, jump and jump-register redirects, and drives the 11-bit word address into the instruction memory.
- Registers the returned instruction into the IF/ID pipeline register consumed by decode.
- Instruction memory read is combinational: the instruction for the current PC is valid in the same cycle.

Parameters:
- TEXT_BASE, 32'h0040_0000, byte address of instruction word 0; PC reset value.
- IMEM_AW, 11, instruction memory word-address width (2048 words).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC and IF/ID (load-use hazard from decode)
- redirect  in  1  decode requests a PC change this cycle
- redirect_sel  in  2  00 branch, 01 jump (J/JAL), 10 jump-register, 11 reserved
- br_offset  in  16  raw branch immediate from the IF/ID instruction
- j_target  in  26  raw jump target field
- jr_addr  in  32  register value for JR/JALR
- imem_addr  out  IMEM_AW  word address to instruction memory
- imem_instr  in  32  instruction returned combinationally
- id_instr  out  32  IF/ID instruction
- id_pc  out  32  PC of id_instr
- id_pc_plus4  out  32  id_pc + 4 (link value, branch base)
- id_valid  out  1  IF/ID holds a real instruction
- fetch_fault  out  1  sticky: PC misaligned or out of memory range

Behaviour:
- Reset (async, rst_n=0):
  - pc=TEXT_BASE, state=BOOT.
  - id_instr=0, id_pc=0, id_pc_plus4=0, id_valid=0, fetch_fault=0.
- imem_addr = (pc - TEXT_BASE)[IMEM_AW+1:2], combinational from pc.
- States:
  - BOOT: one cycle after reset release; no fetch, id_valid stays 0; next state RUN. This gives the reset-release margin.
  - RUN: normal fetch.
  - HALT: entered on fault; pc frozen, id_valid=0, fetch_fault=1. Left only by reset.
- Fault check (RUN only): pc[1:0]!=0, or (pc - TEXT_BASE) >= 4<<IMEM_AW (unsigned, so pc < TEXT_BASE also faults).
  - On a fault, IF/ID loads a bubble instead of the instruction and state goes to HALT.
- pc_plus4 = pc + 4, 32-bit wrap.
- Redirect targets. Branch and jump bases use id_pc_plus4, the delay-slot-free architectural PC+4 of the branch in IF/ID:
  - branch: id_pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00}.
  - jump: {id_pc_plus4[31:28], j_target, 2'b00}.
  - jump-register: jr_addr, used unmodified; misalignment is caught by the fault check next cycle.
  - sel 11: treated as no redirect.
- Per-cycle priority in RUN:
  1. stall=1: pc and IF/ID hold. redirect is ignored; decode re-asserts it after the stall.
  2. redirect=1 with a valid sel: pc <= target. IF/ID loads a bubble (id_instr=0 NOP, id_valid=0, id_pc and id_pc_plus4 = 0) to flush the wrong-path fetch. Single-cycle penalty.
  3. Otherwise: pc <= pc_plus4. IF/ID <= {imem_instr, pc, pc_plus4}, id_valid=1.
- Reset asserted mid-operation aborts immediately, with no pending redirect retained.
- No combinational path from imem_instr to any output other than through the IF/ID register.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - TEXT_BASE.
  - redirect_sel encodings: SEL_BR, SEL_J, SEL_JR.
  - fetch state enum: BOOT, RUN, HALT.
  - NOP_INSTR = 32'h0000_0000.
- One natural sub-module: next_pc_calc. Combinational mux of pc_plus4, branch, jump and jr targets, plus the fault compare.
- The fetch_unit top keeps the pc register, FSM and IF/ID register.

Test Plan:
- Reset, release, 4 cycles with imem_instr = word index:
  - imem_addr goes 0, 0 (BOOT), 1, 2.
  - id_valid first rises 2 cycles after release, with id_pc=0x00400000.
- Sequential fetch at pc=0x00400010 → imem_addr=4. Next cycle id_instr=imem data, id_pc_plus4=0x00400014.
- Branch: id_pc_plus4=0x00400020, br_offset=16'hFFFE, redirect sel=00 → pc=0x00400018, and id_valid=0 for exactly one cycle.
- stall=1 for 3 cycles with redirect=1 → pc, imem_addr and id_* unchanged. Redirect is taken only on the first non-stall cycle.
- JR to 0x00402000 (word 2048, out of range) → next cycle fetch_fault=1, state HALT, id_valid=0. Stays held until rst_n pulse, then pc=0x00400000.
- JR to 0x00400006 → fetch_fault=1. Asserting rst_n=0 mid-cycle clears all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the MIPS core: text segment base, redirect select
// encodings, fetch FSM states and the NOP encoding used for pipeline bubbles.
package cpu_defs_pkg;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

  localparam logic [1:0] SEL_BR = 2'b00;
  localparam logic [1:0] SEL_J  = 2'b01;
  localparam logic [1:0] SEL_JR = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection (sequential, branch, jump, jump-register)
// and the alignment / instruction-memory range check on the current PC.
module next_pc_calc
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE = cpu_defs_pkg::TEXT_BASE,
  parameter int          IMEM_AW   = 11
) (
  input  logic [31:0] pc,
  input  logic [31:0] id_pc_plus4,
  input  logic        redirect,
  input  logic [1:0]  redirect_sel,
  input  logic [15:0] br_offset,
  input  logic [25:0] j_target,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc_plus4,
  output logic        redir_take,
  output logic [31:0] redir_target,
  output logic        fault
);

  localparam logic [31:0] IMEM_BYTES = 32'd4 << IMEM_AW;

  logic [31:0] br_target;
  logic [31:0] j_addr;
  logic [31:0] pc_off;

  assign pc_plus4  = pc + 32'd4;
  assign br_target = id_pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign j_addr    = {id_pc_plus4[31:28], j_target, 2'b00};

  // Unsigned offset makes a PC below the text base wrap high and fail the range test.
  assign pc_off = pc - TEXT_BASE;
  assign fault  = (pc[1:0] != 2'b00) || (pc_off >= IMEM_BYTES);

  always_comb begin
    redir_take   = redirect;
    redir_target = pc_plus4;
    case (redirect_sel)
      SEL_BR:  redir_target = br_target;
      SEL_J:   redir_target = j_addr;
      SEL_JR:  redir_target = jr_addr;
      default: redir_take   = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID
// pipeline register feeding decode.
module fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE = cpu_defs_pkg::TEXT_BASE,
  parameter int          IMEM_AW   = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [1:0]         redirect_sel,
  input  logic [15:0]        br_offset,
  input  logic [25:0]        j_target,
  input  logic [31:0]        jr_addr,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_instr,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc_plus4,
  output logic               id_valid,
  output logic               fetch_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_pc_plus4_q, id_pc_plus4_d;
  logic         id_valid_q, id_valid_d;
  logic         fetch_fault_q, fetch_fault_d;

  logic [31:0]  pc_plus4;
  logic         redir_take;
  logic [31:0]  redir_target;
  logic         fault;
  logic [31:0]  pc_off;

  next_pc_calc #(
    .TEXT_BASE (TEXT_BASE),
    .IMEM_AW   (IMEM_AW)
  ) u_next_pc_calc (
    .pc           (pc_q),
    .id_pc_plus4  (id_pc_plus4_q),
    .redirect     (redirect),
    .redirect_sel (redirect_sel),
    .br_offset    (br_offset),
    .j_target     (j_target),
    .jr_addr      (jr_addr),
    .pc_plus4     (pc_plus4),
    .redir_take   (redir_take),
    .redir_target (redir_target),
    .fault        (fault)
  );

  assign pc_off    = pc_q - TEXT_BASE;
  assign imem_addr = pc_off[IMEM_AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (fault) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // Fault outranks stall so a bad PC can never linger behind a load-use hold.
  always_comb begin
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    fetch_fault_d = fetch_fault_q;
    if (state_q == RUN) begin
      if (fault || (!stall && redir_take)) begin
        id_instr_d    = NOP_INSTR;
        id_pc_d       = 32'd0;
        id_pc_plus4_d = 32'd0;
        id_valid_d    = 1'b0;
        if (fault) fetch_fault_d = 1'b1;
        else       pc_d          = redir_target;
      end else if (!stall) begin
        pc_d          = pc_plus4;
        id_instr_d    = imem_instr;
        id_pc_d       = pc_q;
        id_pc_plus4_d = pc_plus4;
        id_valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= TEXT_BASE;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      id_valid_q    <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;
  assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot sequence, sequential fetch, branch/jump/JR
// redirects, stall priority, fault halting and asynchronous reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [1:0]  redirect_sel;
  logic [15:0] br_offset;
  logic [25:0] j_target;
  logic [31:0] jr_addr;
  logic [10:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        fetch_fault;

  int n_cmp;
  int n_err;

  fetch_unit #(
    .TEXT_BASE (32'h0040_0000),
    .IMEM_AW   (11)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_sel (redirect_sel),
    .br_offset    (br_offset),
    .j_target     (j_target),
    .jr_addr      (jr_addr),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc_plus4  (id_pc_plus4),
    .id_valid     (id_valid),
    .fetch_fault  (fetch_fault)
  );

  // Instruction memory model: each word carries its own index in the low bits.
  assign imem_instr = 32'hC0DE_0000 | {21'd0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_redir(input logic en, input logic [1:0] sel);
    redirect     = en;
    redirect_sel = sel;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_sel = 2'b00;
    br_offset = 16'h0000;
    j_target = 26'h0;
    jr_addr = 32'h0;

    #12;
    chk("rst_addr",  {21'd0, imem_addr}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc",    id_pc, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    step();  // BOOT
    chk("boot_addr",  {21'd0, imem_addr}, 32'd0);
    chk("boot_valid", {31'd0, id_valid}, 32'd0);
    step();
    chk("f0_addr",  {21'd0, imem_addr}, 32'd1);
    chk("f0_valid", {31'd0, id_valid}, 32'd1);
    chk("f0_pc",    id_pc, 32'h0040_0000);
    chk("f0_instr", id_instr, 32'hC0DE_0000);
    chk("f0_pc4",   id_pc_plus4, 32'h0040_0004);
    step();
    chk("f1_addr", {21'd0, imem_addr}, 32'd2);
    chk("f1_pc",   id_pc, 32'h0040_0004);
    step();
    step();
    chk("seq_addr4", {21'd0, imem_addr}, 32'd4);
    step();
    chk("seq_instr", id_instr, 32'hC0DE_0004);
    chk("seq_pc4",   id_pc_plus4, 32'h0040_0014);
    step();
    step();
    step();
    chk("pre_br_pc4", id_pc_plus4, 32'h0040_0020);

    // Branch back by two words from id_pc_plus4.
    br_offset = 16'hFFFE;
    set_redir(1'b1, 2'b00);
    step();
    set_redir(1'b0, 2'b00);
    chk("br_addr",  {21'd0, imem_addr}, 32'd6);
    chk("br_valid", {31'd0, id_valid}, 32'd0);
    chk("br_idpc",  id_pc, 32'd0);
    step();
    chk("br2_valid", {31'd0, id_valid}, 32'd1);
    chk("br2_pc",    id_pc, 32'h0040_0018);
    chk("br2_addr",  {21'd0, imem_addr}, 32'd7);

    // Stall with a pending JR: nothing moves until stall drops.
    stall = 1'b1;
    jr_addr = 32'h0040_0100;
    set_redir(1'b1, 2'b10);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_addr",  {21'd0, imem_addr}, 32'd7);
      chk("stl_pc",    id_pc, 32'h0040_0018);
      chk("stl_valid", {31'd0, id_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    set_redir(1'b0, 2'b00);
    chk("jr_addr",  {21'd0, imem_addr}, 32'h40);
    chk("jr_valid", {31'd0, id_valid}, 32'd0);
    step();
    chk("jr2_pc",  id_pc, 32'h0040_0100);
    chk("jr2_pc4", id_pc_plus4, 32'h0040_0104);
    chk("jr2_addr", {21'd0, imem_addr}, 32'h41);

    // J: {id_pc_plus4[31:28], 26'h0100080, 2'b00} = 0x00400200.
    j_target = 26'h010_0080;
    set_redir(1'b1, 2'b01);
    step();
    chk("j_addr",  {21'd0, imem_addr}, 32'h80);
    chk("j_valid", {31'd0, id_valid}, 32'd0);
    // Reserved select behaves as plain sequential fetch.
    set_redir(1'b1, 2'b11);
    step();
    set_redir(1'b0, 2'b00);
    chk("rsv_pc",    id_pc, 32'h0040_0200);
    chk("rsv_valid", {31'd0, id_valid}, 32'd1);
    chk("rsv_addr",  {21'd0, imem_addr}, 32'h81);

    // JR to the first word past the end of instruction memory.
    jr_addr = 32'h0040_2000;
    set_redir(1'b1, 2'b10);
    step();
    set_redir(1'b0, 2'b00);
    chk("oor_valid", {31'd0, id_valid}, 32'd0);
    chk("oor_fault0", {31'd0, fetch_fault}, 32'd0);
    step();
    chk("oor_fault", {31'd0, fetch_fault}, 32'd1);
    chk("oor_valid2", {31'd0, id_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("halt_fault", {31'd0, fetch_fault}, 32'd1);
      chk("halt_valid", {31'd0, id_valid}, 32'd0);
      chk("halt_instr", id_instr, 32'd0);
    end

    rst_n = 1'b0;
    #1;
    chk("rp_fault", {31'd0, fetch_fault}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rp_boot_valid", {31'd0, id_valid}, 32'd0);
    chk("rp_boot_addr",  {21'd0, imem_addr}, 32'd0);
    step();
    chk("rp_pc",    id_pc, 32'h0040_0000);
    chk("rp_valid", {31'd0, id_valid}, 32'd1);

    // Misaligned JR target, then asynchronous reset between clock edges.
    jr_addr = 32'h0040_0006;
    set_redir(1'b1, 2'b10);
    step();
    set_redir(1'b0, 2'b00);
    chk("mis_addr",   {21'd0, imem_addr}, 32'd1);
    chk("mis_fault0", {31'd0, fetch_fault}, 32'd0);
    step();
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_valid", {31'd0, id_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("ar_fault", {31'd0, fetch_fault}, 32'd0);
    chk("ar_valid", {31'd0, id_valid}, 32'd0);
    chk("ar_pc",    id_pc, 32'd0);
    chk("ar_pc4",   id_pc_plus4, 32'd0);
    chk("ar_instr", id_instr, 32'd0);
    chk("ar_addr",  {21'd0, imem_addr}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
